amdc_dac_axi_lite_regs: RTL and testbench
=========================================

# amdc_dac_axi_lite_regs

AXI4-Lite slave (responder) register file for the AMDC DAC IP. It terminates the AXI4-Lite transactions that the PS, or a master VIP in simulation, issues to the DAC: single-beat writes and reads to eight 32-bit registers. It drives the register contents and per-register write pulses into the DAC datapath. It also exposes one read-only status word.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: data bus width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 5: byte-address width covering 8 words.
- `C_NUM_REGS`, 8: register count; index 7 is the read-only status register.
- `S_AXI_ACLK` in 1: the single clock.
- `S_AXI_ARESET` in 1: synchronous, active-high reset.
- `S_AXI_AWADDR` in 5; `S_AXI_AWPROT` in 3 (ignored); `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1.
- `S_AXI_WDATA` in 32; `S_AXI_WSTRB` in 4; `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1.
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1.
- `S_AXI_ARADDR` in 5; `S_AXI_ARPROT` in 3 (ignored); `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1.
- `S_AXI_RDATA` out 32; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1.
- `reg_out` out 256: registers 0..7, with reg k at bits [32k+31:32k]; the reg 7 slice is tied 0.
- `wr_pulse` out 8: one-cycle strobe per register on a committed write.
- `status_in` in 32: returned on reads of reg 7.

## Operation
- **Decode:** word index is `addr[4:2]`; `addr[1:0]` is ignored.
- **Write channel:** AW and W are accepted independently into two holding slots, `aw_held` and `w_held`.
  - `AWREADY = !aw_held && !BVALID && !reset`.
  - `WREADY = !w_held && !BVALID && !reset`.
  - Both readies are derived from registered state only, never from VALID.
- **Write commit:** occurs in the cycle after the later of the two handshakes, i.e. once both slots are full.
  - Byte lanes with `WSTRB[b]=1` are updated; other lanes keep their value.
  - `wr_pulse[idx]` goes high for exactly one cycle.
  - `BVALID` rises.
  - Both slots clear.
- **Write response:**
  - `BRESP=OKAY` (2'b00) for indices 0..6.
  - For index 7, `BRESP=SLVERR` (2'b10), no register changes, and no `wr_pulse`.
  - `BVALID` and `BRESP` hold until `BREADY`. AW/W readies reassert in the cycle after the B handshake.
- **Read channel:** `ARREADY = !RVALID && !reset`.
  - On an AR handshake in cycle N, `RDATA` takes the register value, or `status_in` for index 7, sampled at the edge ending N.
  - `RVALID` rises in N+1. `RRESP` is always OKAY.
  - `RDATA`/`RVALID` are held stable until `RREADY`. `ARREADY` reasserts the cycle after the R handshake.
- **Channel independence:** the read and write paths are independent. A read sampled at the same edge as a write commit returns the pre-write value.
- **Reset:** `S_AXI_ARESET` sampled high forces the following state on the next edge, and holds it while reset stays high:
  - all registers = 0;
  - slots empty; any half-captured transaction is discarded with no B or R issued;
  - all READY/VALID outputs = 0;
  - `BRESP`/`RRESP`/`RDATA` = 0;
  - `wr_pulse` = 0.

## Timing
- **Write, AW and W together:** both handshakes at N → commit, `BVALID` and `wr_pulse` at N+1. If `BREADY` is high at N+1, readies return at N+2. Peak rate is 1 write per 2 cycles.
- **Write, AW and W split:** AW at N, W at N+k → commit at N+k+1. While waiting, `AWREADY` stays low, so a second AW is not accepted.
- **Read:** AR at N → `RVALID` at N+1. With `RREADY` high, `ARREADY` returns at N+2.
- **Back-pressure:** `BREADY` or `RREADY` low holds the response indefinitely. Readies on that path stay low; no data is lost.
- **After reset:** readies first assert in the cycle after the edge at which reset is sampled low.

## Test plan
- **Sequential round trip:** write 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C with full strobes, then read back the same addresses → each B = OKAY, each read returns 0x1..0x4, and `wr_pulse[0..3]` each fire once.
- **Partial strobes:** write 0xAABBCCDD to 0x10 with WSTRB=4'hF, then 0x11223344 with WSTRB=4'b0101 → readback = 0xAA22CC44.
- **Split AW/W:** AW to 0x14 at cycle 0, W of 0xDEADBEEF at cycle 5 → `AWREADY` low during cycles 1-5, commit and `BVALID` at cycle 6, then reg 5 = 0xDEADBEEF.
- **Back-pressure:** hold `BREADY` low for 5 cycles after `BVALID` → BRESP stable and AW/W readies low throughout. Same for R: `RDATA` stable and `ARREADY` low while `RREADY` is low.
- **Read-only register:** with `status_in`=0x0000CAFE, write 0x12345678 to 0x1C → BRESP=SLVERR and `wr_pulse`=0. A read of 0x1C returns 0x0000CAFE.
- **Reset mid-operation:** complete the AW handshake, assert reset before W, release reset, then read 0x00 → no BVALID is ever issued and the read returns 0x00000000.

Source files
------------

// File: rtl/amdc_dac_axi_lite_regs.sv
// -----------------------------------------------------------------------------
// amdc_dac_axi_lite_regs
//
// AXI4-Lite responder register file for the AMDC DAC IP. It holds eight
// 32-bit word slots. Slots 0..6 are read/write control registers. Slot 7 is a
// read-only status word that is returned from status_in.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESET   : single clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W*       : write address / write data channels
//   S_AXI_B*                   : write response (OKAY, or SLVERR for slot 7)
//   S_AXI_AR* / S_AXI_R*       : read address / read data channels
//   reg_out                    : slot k on bits [32k+31:32k], slot 7 tied to 0
//   wr_pulse                   : one-cycle strobe per slot on a committed write
//   status_in                  : value returned on reads of slot 7
// -----------------------------------------------------------------------------
module amdc_dac_axi_lite_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_NUM_REGS         = 8
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [C_NUM_REGS-1:0]                    wr_pulse,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            status_in
);

    localparam int            DW          = C_S_AXI_DATA_WIDTH;
    localparam int            SW          = C_S_AXI_DATA_WIDTH / 8;
    localparam int            IW          = $clog2(C_NUM_REGS);
    localparam logic [IW-1:0] STATUS_IDX  = IW'(C_NUM_REGS - 1);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    // Merge new data into an old word, byte lane by byte lane, under a strobe.
    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic                active_r;
    logic                aw_held_r;
    logic [IW-1:0]       aw_idx_r;
    logic                w_held_r;
    logic [DW-1:0]       w_data_r;
    logic [SW-1:0]       w_strb_r;
    logic                bvalid_r;
    logic [1:0]          bresp_r;
    logic                rvalid_r;
    logic [DW-1:0]       rdata_r;
    logic [C_NUM_REGS-1:0] wr_pulse_r;
    logic [DW-1:0]       regs_r [C_NUM_REGS];

    logic                aw_hs_s;
    logic                w_hs_s;
    logic                ar_hs_s;
    logic                commit_s;
    logic [IW-1:0]       commit_idx_s;
    logic [DW-1:0]       commit_data_s;
    logic [SW-1:0]       commit_strb_s;
    logic [IW-1:0]       ar_idx_s;
    logic [DW-1:0]       rd_word_s;
    logic                unused_s;

    // Protection bits and the byte offset within a word carry no meaning here.
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies depend only on flops; active_r delays them one cycle past reset.
    assign S_AXI_AWREADY = active_r && !aw_held_r && !bvalid_r;
    assign S_AXI_WREADY  = active_r && !w_held_r  && !bvalid_r;
    assign S_AXI_ARREADY = active_r && !rvalid_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign wr_pulse      = wr_pulse_r;

    assign aw_hs_s  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs_s   = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs_s  = S_AXI_ARVALID && S_AXI_ARREADY;
    // A write commits at the edge where the second of the two slots fills.
    assign commit_s = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
    assign ar_idx_s = S_AXI_ARADDR[IW+1:2];

    // Pick the write address/data from the holding slot or straight off the bus.
    always_comb begin
        commit_idx_s  = S_AXI_AWADDR[IW+1:2];
        commit_data_s = S_AXI_WDATA;
        commit_strb_s = S_AXI_WSTRB;
        if (aw_held_r) begin
            commit_idx_s = aw_idx_r;
        end else begin
            commit_idx_s = S_AXI_AWADDR[IW+1:2];
        end
        if (w_held_r) begin
            commit_data_s = w_data_r;
            commit_strb_s = w_strb_r;
        end else begin
            commit_data_s = S_AXI_WDATA;
            commit_strb_s = S_AXI_WSTRB;
        end
    end

    // Read mux: slot 7 returns the live status word instead of storage.
    always_comb begin
        rd_word_s = regs_r[ar_idx_s];
        if (ar_idx_s == STATUS_IDX) begin
            rd_word_s = status_in;
        end else begin
            rd_word_s = regs_r[ar_idx_s];
        end
    end

    // Readies stay low until the first edge that samples reset low.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            active_r <= 1'b0;
        end else begin
            active_r <= 1'b1;
        end
    end

    // Write path: slot capture, commit into storage, pulse and B response.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_held_r  <= 1'b0;
            aw_idx_r   <= '0;
            w_held_r   <= 1'b0;
            w_data_r   <= '0;
            w_strb_r   <= '0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            wr_pulse_r <= '0;
            for (int k = 0; k < C_NUM_REGS; k++) begin
                regs_r[k] <= '0;
            end
        end else begin
            wr_pulse_r <= '0;
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                aw_idx_r  <= S_AXI_AWADDR[IW+1:2];
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                w_data_r <= S_AXI_WDATA;
                w_strb_r <= S_AXI_WSTRB;
            end
            if (commit_s) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                if (commit_idx_s == STATUS_IDX) begin
                    bresp_r <= RESP_SLVERR;
                end else begin
                    bresp_r                  <= RESP_OKAY;
                    regs_r[commit_idx_s]     <= apply_strb(regs_r[commit_idx_s],
                                                           commit_data_s, commit_strb_s);
                    wr_pulse_r[commit_idx_s] <= 1'b1;
                end
            end else if (bvalid_r && S_AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Read path: capture the word at the AR handshake and hold it until taken.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_word_s;
        end else if (rvalid_r && S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
        end
    end

    // Expose storage; the status slot is not storage and reads back as zero.
    for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg_out
        if (k == C_NUM_REGS - 1) begin : g_status
            assign reg_out[k*DW +: DW] = '0;
        end else begin : g_rw
            assign reg_out[k*DW +: DW] = regs_r[k];
        end
    end

endmodule

// File: tb/tb_amdc_dac_axi_lite_regs.sv
module tb_amdc_dac_axi_lite_regs;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [4:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] reg_out;
    logic [7:0]   wr_pulse;
    logic [31:0]  status_in;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    amdc_dac_axi_lite_regs dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .reg_out      (reg_out),
        .wr_pulse     (wr_pulse),
        .status_in    (status_in)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (transaction bookkeeping) -------------
    logic [31:0] m_regs [8];
    bit          m_alive, m_in_reset, m_awp, m_wp, m_bp, m_rp, chk_en;
    int          m_aw_idx;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;
    logic [31:0] m_rdata;
    logic [7:0]  m_pulse;

    always @(posedge clk) begin : model
        bit awr, wrr, arr;
        awr = m_alive && !m_awp && !m_bp;
        wrr = m_alive && !m_wp && !m_bp;
        arr = m_alive && !m_rp;
        m_pulse = 8'h00;
        if (rst) begin
            for (int k = 0; k < 8; k++) m_regs[k] = 32'h0;
            m_alive = 1'b0; m_in_reset = 1'b1; chk_en = 1'b1;
            m_awp = 1'b0; m_wp = 1'b0; m_bp = 1'b0; m_rp = 1'b0;
            m_bresp = 2'b00; m_rdata = 32'h0;
        end else begin
            m_in_reset = 1'b0;
            if (m_rp && rready) m_rp = 1'b0;
            if (arr && arvalid) begin
                m_rp = 1'b1;
                if (araddr[4:2] == 3'd7) m_rdata = status_in;
                else m_rdata = m_regs[araddr[4:2]];
            end
            if (m_bp && bready) m_bp = 1'b0;
            if (awr && awvalid) begin m_awp = 1'b1; m_aw_idx = int'(awaddr[4:2]); end
            if (wrr && wvalid) begin m_wp = 1'b1; m_wdata = wdata; m_wstrb = wstrb; end
            if (m_awp && m_wp) begin
                if (m_aw_idx == 7) begin
                    m_bresp = 2'b10;
                end else begin
                    m_bresp = 2'b00;
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) m_regs[m_aw_idx][8*b +: 8] = m_wdata[8*b +: 8];
                    m_pulse[m_aw_idx] = 1'b1;
                end
                m_bp = 1'b1; m_awp = 1'b0; m_wp = 1'b0;
            end
            m_alive = 1'b1;
        end
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin : compare
        logic [255:0] exp_regs;
        if (chk_en) begin
            for (int k = 0; k < 8; k++) exp_regs[32*k +: 32] = (k == 7) ? 32'h0 : m_regs[k];
            chk("awready", awready, m_alive && !m_awp && !m_bp);
            chk("wready",  wready,  m_alive && !m_wp && !m_bp);
            chk("arready", arready, m_alive && !m_rp);
            chk("bvalid",  bvalid,  m_bp);
            chk("rvalid",  rvalid,  m_rp);
            chk("wr_pulse", wr_pulse, m_pulse);
            chk("reg_out", reg_out, exp_regs);
            if (m_bp || m_in_reset) chk("bresp", bresp, m_bresp);
            if (m_rp || m_in_reset) begin
                chk("rdata", rdata, m_rdata);
                chk("rresp", rresp, 2'b00);
            end
        end
    end

    // Observation counters used by the directed literal checks.
    int   pulse_cnt [8];
    int   bv_rise = 0;
    logic bv_prev = 1'b0;
    initial for (int k = 0; k < 8; k++) pulse_cnt[k] = 0;
    always @(negedge clk) begin
        for (int k = 0; k < 8; k++) if (wr_pulse[k] === 1'b1) pulse_cnt[k]++;
        if (bvalid === 1'b1 && bv_prev !== 1'b1) bv_rise++;
        bv_prev = bvalid;
    end

    // ---------------- drivers (called at posedge+1) ---------------------------
    function automatic bit ready_of(input int ch);
        case (ch)
            0:       return awready;
            1:       return wready;
            default: return arready;
        endcase
    endfunction

    task automatic wait_hs(input int ch, input string nm);
        bit ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (ready_of(ch)) ok = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got no ready, expected handshake within 300 cycles", nm);
        end
    endtask

    task automatic drive_aw(input logic [4:0] a, input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        awaddr = a; awprot = 3'($urandom_range(0, 7)); awvalid = 1'b1;
        wait_hs(0, "aw_hs");
        awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1;
        wait_hs(1, "w_hs");
        wvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [4:0] a, input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        araddr = a; arprot = 3'($urandom_range(0, 7)); arvalid = 1'b1;
        wait_hs(2, "ar_hs");
        arvalid = 1'b0;
    endtask

    task automatic take_b(input int hold, output logic [1:0] resp);
        bit ok = 1'b0;
        resp = 2'bxx;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (bvalid) ok = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b_wait: got no BVALID, expected it within 300 cycles");
        end else begin
            repeat (hold) begin @(posedge clk); #1; end
            bready = 1'b1;
            @(negedge clk); resp = bresp;
            @(posedge clk); #1;
            bready = 1'b0;
        end
    endtask

    task automatic take_r(input int hold, output logic [31:0] data);
        bit ok = 1'b0;
        data = 32'hx;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (rvalid) ok = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL r_wait: got no RVALID, expected it within 300 cycles");
        end else begin
            repeat (hold) begin @(posedge clk); #1; end
            rready = 1'b1;
            @(negedge clk); data = rdata;
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int hold,
                             output logic [1:0] resp);
        fork
            drive_aw(a, aw_dly);
            drive_w(d, s, w_dly);
        join
        take_b(hold, resp);
    endtask

    task automatic axi_read(input logic [4:0] a, input int dly, input int hold,
                            output logic [31:0] data);
        drive_ar(a, dly);
        take_r(hold, data);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          snap [8];
        int          bv_snap;

        rst = 1'b1;
        awaddr = 5'h0; awprot = 3'h0; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr = 5'h0; arprot = 3'h0; arvalid = 1'b0; rready = 1'b0;
        status_in = 32'h0;

        // Reset state and the first-ready boundary.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("pre_rel_awready", awready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_awready", awready, 1'b1);
        chk("rel_arready", arready, 1'b1);
        @(posedge clk); #1;

        // Sequential round trip.
        for (int k = 0; k < 8; k++) snap[k] = pulse_cnt[k];
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, resp);
            chk("rt_bresp", resp, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), 0, 0, rd);
            chk("rt_rdata", rd, 32'(i + 1));
        end
        for (int k = 0; k < 4; k++) chk("rt_pulse_cnt", pulse_cnt[k] - snap[k], 1);

        // Partial strobes.
        axi_write(5'h10, 32'hAABBCCDD, 4'hF, 0, 0, 0, resp);
        axi_write(5'h10, 32'h11223344, 4'b0101, 0, 0, 0, resp);
        axi_read(5'h10, 0, 0, rd);
        chk("strb_rdata", rd, 32'hAA22CC44);
        chk("strb_model", m_regs[4], 32'hAA22CC44);

        // Split AW/W: W arrives five cycles after AW.
        axi_write(5'h14, 32'hDEADBEEF, 4'hF, 0, 5, 0, resp);
        chk("split_bresp", resp, 2'b00);
        axi_read(5'h14, 0, 0, rd);
        chk("split_rdata", rd, 32'hDEADBEEF);

        // Back-pressure on B and R.
        axi_write(5'h18, 32'h0BADF00D, 4'hF, 0, 0, 5, resp);
        chk("bp_bresp", resp, 2'b00);
        axi_read(5'h18, 0, 5, rd);
        chk("bp_rdata", rd, 32'h0BADF00D);

        // Read-only status slot.
        status_in = 32'h0000CAFE;
        for (int k = 0; k < 8; k++) snap[k] = pulse_cnt[k];
        axi_write(5'h1C, 32'h12345678, 4'hF, 0, 0, 0, resp);
        chk("ro_bresp", resp, 2'b10);
        for (int k = 0; k < 8; k++) chk("ro_no_pulse", pulse_cnt[k] - snap[k], 0);
        axi_read(5'h1C, 0, 0, rd);
        chk("ro_rdata", rd, 32'h0000CAFE);
        chk("ro_reg_out7", reg_out[255:224], 32'h0);

        // Reset with only the AW half captured.
        bv_snap = bv_rise;
        drive_aw(5'h00, 0);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        axi_read(5'h00, 0, 0, rd);
        repeat (5) begin @(posedge clk); #1; end
        chk("rstmid_no_b", bv_rise - bv_snap, 0);
        chk("rstmid_rdata", rd, 32'h0);
        chk("rstmid_model", m_regs[1], 32'h0);

        // Randomized concurrent traffic with back-pressure and split timing.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    axi_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0,
                              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : 0,
                              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0,
                              resp);
                end
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    status_in = $urandom;
                    axi_read(5'($urandom_range(0, 31)),
                             ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0,
                             ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0,
                             rd);
                end
            end
        join

        repeat (3) begin @(posedge clk); #1; end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
